axi4_lite_arbiter_2to1: RTL and testbench

//  Shares one AXI4-Lite slave (e.g. multiplier register peripheral) between two AXI4-Lite masters.

---
 rtl/axi4_lite_arbiter_2to1.sv | 156 +++++++++++++++
 tb/tb_axi4_lite_arbiter_2to1.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. Write and read paths each own an
// independent round-robin FSM; the grant is held for the whole transaction.
module axi4_lite_arbiter_2to1 #(
   parameter int ASZ = 4,
   parameter int DSZ = 8
) (
   input  logic             clk,
   input  logic             _rst,
   input  logic [2*ASZ-1:0] m_awaddr,
   input  logic [1:0]       m_awvalid,
   output logic [1:0]       m_awready,
   input  logic [2*DSZ-1:0] m_wdata,
   input  logic [1:0]       m_wvalid,
   output logic [1:0]       m_wready,
   output logic [1:0]       m_bresp,
   output logic [1:0]       m_bvalid,
   input  logic [1:0]       m_bready,
   input  logic [2*ASZ-1:0] m_araddr,
   input  logic [1:0]       m_arvalid,
   output logic [1:0]       m_arready,
   output logic [2*DSZ-1:0] m_rdata,
   output logic [1:0]       m_rvalid,
   input  logic [1:0]       m_rready,
   output logic [1:0]       m_rresp,
   output logic [ASZ-1:0]   s_awaddr,
   output logic             s_awvalid,
   input  logic             s_awready,
   output logic [DSZ-1:0]   s_wdata,
   output logic             s_wvalid,
   input  logic             s_wready,
   input  logic             s_bresp,
   input  logic             s_bvalid,
   output logic             s_bready,
   output logic [ASZ-1:0]   s_araddr,
   output logic             s_arvalid,
   input  logic             s_arready,
   input  logic [DSZ-1:0]   s_rdata,
   input  logic             s_rvalid,
   input  logic             s_rresp,
   output logic             s_rready
);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t        wstate, wstate_nxt;
   rstate_t        rstate, rstate_nxt;
   logic           wgnt, wgnt_nxt, wlast, wlast_nxt;
   logic           rgnt, rgnt_nxt, rlast, rlast_nxt;
   logic [ASZ-1:0] awaddr_g, araddr_g;
   logic [DSZ-1:0] wdata_g;

   assign awaddr_g = wgnt ? m_awaddr[2*ASZ-1:ASZ] : m_awaddr[ASZ-1:0];
   assign wdata_g  = wgnt ? m_wdata[2*DSZ-1:DSZ]  : m_wdata[DSZ-1:0];
   assign araddr_g = rgnt ? m_araddr[2*ASZ-1:ASZ] : m_araddr[ASZ-1:0];

   // last=1 out of reset so master 0 wins the first contention
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         wstate <= W_IDLE;
         wgnt   <= 1'b0;
         wlast  <= 1'b1;
         rstate <= R_IDLE;
         rgnt   <= 1'b0;
         rlast  <= 1'b1;
      end else begin
         wstate <= wstate_nxt;
         wgnt   <= wgnt_nxt;
         wlast  <= wlast_nxt;
         rstate <= rstate_nxt;
         rgnt   <= rgnt_nxt;
         rlast  <= rlast_nxt;
      end
   end

   always_comb begin
      wstate_nxt = wstate;
      wgnt_nxt   = wgnt;
      wlast_nxt  = wlast;
      m_awready  = '0;
      m_wready   = '0;
      m_bvalid   = '0;
      m_bresp    = '0;
      s_awaddr   = '0;
      s_awvalid  = 1'b0;
      s_wdata    = '0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (wstate)
         W_IDLE: if (|m_awvalid) begin
            wgnt_nxt   = (&m_awvalid) ? ~wlast : m_awvalid[1];
            wstate_nxt = W_ADDR;
         end
         W_ADDR: begin
            s_awaddr        = awaddr_g;
            s_awvalid       = m_awvalid[wgnt];
            m_awready[wgnt] = s_awready;
            if (m_awvalid[wgnt] && s_awready) wstate_nxt = W_DATA;
         end
         W_DATA: begin
            s_wdata        = wdata_g;
            s_wvalid       = m_wvalid[wgnt];
            m_wready[wgnt] = s_wready;
            if (m_wvalid[wgnt] && s_wready) wstate_nxt = W_RESP;
         end
         W_RESP: begin
            m_bvalid[wgnt] = s_bvalid;
            m_bresp[wgnt]  = s_bresp;
            s_bready       = m_bready[wgnt];
            if (s_bvalid && m_bready[wgnt]) begin
               wlast_nxt  = wgnt;
               wstate_nxt = W_IDLE;
            end
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      rstate_nxt = rstate;
      rgnt_nxt   = rgnt;
      rlast_nxt  = rlast;
      m_arready  = '0;
      m_rvalid   = '0;
      m_rresp    = '0;
      m_rdata    = '0;
      s_araddr   = '0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      case (rstate)
         R_IDLE: if (|m_arvalid) begin
            rgnt_nxt   = (&m_arvalid) ? ~rlast : m_arvalid[1];
            rstate_nxt = R_ADDR;
         end
         R_ADDR: begin
            s_araddr        = araddr_g;
            s_arvalid       = m_arvalid[rgnt];
            m_arready[rgnt] = s_arready;
            if (m_arvalid[rgnt] && s_arready) rstate_nxt = R_DATA;
         end
         R_DATA: begin
            m_rvalid[rgnt] = s_rvalid;
            m_rresp[rgnt]  = s_rresp;
            if (rgnt) m_rdata[2*DSZ-1:DSZ] = s_rdata;
            else      m_rdata[DSZ-1:0]     = s_rdata;
            s_rready = m_rready[rgnt];
            if (s_rvalid && m_rready[rgnt]) begin
               rlast_nxt  = rgnt;
               rstate_nxt = R_IDLE;
            end
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for axi4_lite_arbiter_2to1: reactive masters and slave,
// a transaction-level reference model compared every cycle, plus literal pins.
module tb_axi4_lite_arbiter_2to1;
   logic        clk, rst_n;
   logic [7:0]  m_awaddr, m_araddr;
   logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready;
   logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, m_rresp;
   logic [15:0] m_wdata, m_rdata;
   logic [3:0]  s_awaddr, s_araddr;
   logic [7:0]  s_wdata, s_rdata;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rresp, s_rready;

   axi4_lite_arbiter_2to1 #(.ASZ(4), .DSZ(8)) dut (
      .clk(clk), ._rst(rst_n),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rready(s_rready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 20) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // master-side transaction lists and results
   logic [3:0] wa[2][16], ra[2][16];
   logic [7:0] wd[2][16], rgot[2][16];
   logic       bgot[2][16], rrgot[2][16];
   int         wn[2], wi[2], rn[2], ri[2];
   bit         aw_done[2], w_done[2], ar_done[2];
   bit         rdy_rand;
   int         worder[$];

   // slave model
   logic [7:0] mem[16];
   logic [3:0] aw_addr, r_addr;
   int         cnt_aw, cnt_w, cnt_ar, b_cnt, r_cnt, stall_max;
   bit         b_pend, r_pend, w_block, bresp_val, rresp_val;

   // per-test captures
   int         ncyc, first_aw;
   logic [3:0] seen_awaddr;
   logic [7:0] seen_wdata;
   logic [1:0] bv_or;
   bit         rv0_seen, cap_swv;

   function automatic int rnd();
      return (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
   endfunction

   function automatic bit all_done();
      return wi[0] >= wn[0] && wi[1] >= wn[1] && ri[0] >= rn[0] && ri[1] >= rn[1];
   endfunction

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         m_awvalid[i] = (wi[i] < wn[i]) && !aw_done[i];
         m_wvalid[i]  = (wi[i] < wn[i]) && !w_done[i];
         m_awaddr[i*4 +: 4] = (wi[i] < 16) ? wa[i][wi[i]] : 4'h0;
         m_wdata[i*8 +: 8]  = (wi[i] < 16) ? wd[i][wi[i]] : 8'h00;
         m_bready[i]  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         m_arvalid[i] = (ri[i] < rn[i]) && !ar_done[i];
         m_araddr[i*4 +: 4] = (ri[i] < 16) ? ra[i][ri[i]] : 4'h0;
         m_rready[i]  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      s_awready = (cnt_aw == 0);
      s_wready  = (cnt_w == 0) && !w_block;
      s_arready = (cnt_ar == 0);
      s_bvalid  = b_pend && (b_cnt == 0);
      s_bresp   = s_bvalid && bresp_val;
      s_rvalid  = r_pend && (r_cnt == 0);
      s_rdata   = s_rvalid ? mem[r_addr] : 8'h00;
      s_rresp   = s_rvalid && rresp_val;
   endtask

   task automatic clear_bench();
      for (int i = 0; i < 2; i++) begin
         wn[i] = 0; wi[i] = 0; rn[i] = 0; ri[i] = 0;
         aw_done[i] = 0; w_done[i] = 0; ar_done[i] = 0;
      end
      cnt_aw = 0; cnt_w = 0; cnt_ar = 0; b_cnt = 0; r_cnt = 0;
      b_pend = 0; r_pend = 0; w_block = 0;
   endtask

   task automatic clear_caps();
      ncyc = 0; first_aw = -1; seen_awaddr = '0; seen_wdata = '0;
      bv_or = '0; rv0_seen = 0; worder.delete();
   endtask

   // one clock: observe handshakes at negedge, update bench state, drive after posedge
   task automatic tick();
      @(negedge clk);
      ncyc++;
      if (s_awvalid && first_aw < 0) first_aw = ncyc;
      if (s_awvalid && s_awready) seen_awaddr = s_awaddr;
      if (s_wvalid && s_wready) seen_wdata = s_wdata;
      bv_or |= m_bvalid;
      rv0_seen |= m_rvalid[0];
      cap_swv = s_wvalid;
      for (int i = 0; i < 2; i++) begin
         if (m_awvalid[i] && m_awready[i]) begin aw_done[i] = 1; worder.push_back(i); end
         if (m_wvalid[i] && m_wready[i]) w_done[i] = 1;
         if (m_bvalid[i] && m_bready[i]) begin
            bgot[i][wi[i]] = m_bresp[i]; wi[i]++; aw_done[i] = 0; w_done[i] = 0;
         end
         if (m_arvalid[i] && m_arready[i]) ar_done[i] = 1;
         if (m_rvalid[i] && m_rready[i]) begin
            rgot[i][ri[i]] = m_rdata[i*8 +: 8]; rrgot[i][ri[i]] = m_rresp[i];
            ri[i]++; ar_done[i] = 0;
         end
      end
      if (s_bvalid && s_bready) b_pend = 0;
      else if (b_pend && b_cnt > 0) b_cnt--;
      if (s_wvalid && s_wready) begin
         mem[aw_addr] = s_wdata; cnt_w = rnd(); b_pend = 1; b_cnt = rnd();
      end else if (s_wvalid && cnt_w > 0) cnt_w--;
      if (s_awvalid && s_awready) begin aw_addr = s_awaddr; cnt_aw = rnd(); end
      else if (s_awvalid && cnt_aw > 0) cnt_aw--;
      if (s_rvalid && s_rready) r_pend = 0;
      else if (r_pend && r_cnt > 0) r_cnt--;
      if (s_arvalid && s_arready) begin
         r_addr = s_araddr; r_pend = 1; r_cnt = rnd(); cnt_ar = rnd();
      end else if (s_arvalid && cnt_ar > 0) cnt_ar--;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_until_done(input int bound, input string nm);
      int n = 0;
      while (!all_done() && n < bound) begin tick(); n++; end
      chk(nm, 32'(all_done()), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_bench();
      drive();
      @(negedge clk);
      chk("reset_vr", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 32'h0);
      @(posedge clk);
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   // Reference model: per path an owner and a position in its channel sequence
   // (0 = arbitration gap, 1.. = AW/W/B or AR/R); outputs follow the owner's channel.
   int mw_own, mw_pos, mw_last, mr_own, mr_pos, mr_last;
   always @(negedge clk) begin : compare
      logic [1:0]  e_awready, e_wready, e_bvalid, e_bresp, e_arready, e_rvalid, e_rresp;
      logic [15:0] e_rdata;
      logic [3:0]  e_saw, e_sar;
      logic [7:0]  e_swd;
      logic        e_sawv, e_swv, e_sbr, e_sarv, e_srr;
      e_awready = '0; e_wready = '0; e_bvalid = '0; e_bresp = '0;
      e_arready = '0; e_rvalid = '0; e_rresp = '0; e_rdata = '0;
      e_saw = '0; e_sar = '0; e_swd = '0;
      e_sawv = 0; e_swv = 0; e_sbr = 0; e_sarv = 0; e_srr = 0;
      if (!rst_n) begin
         mw_own = 0; mw_pos = 0; mw_last = 1;
         mr_own = 0; mr_pos = 0; mr_last = 1;
      end else begin
         if (mw_pos == 0) begin
            if (m_awvalid != 2'b00) begin
               mw_own = (m_awvalid == 2'b11) ? 1 - mw_last : (m_awvalid[1] ? 1 : 0);
               mw_pos = 1;
            end
         end else if (mw_pos == 1) begin
            e_saw = m_awaddr[mw_own*4 +: 4]; e_sawv = m_awvalid[mw_own];
            e_awready[mw_own] = s_awready;
            if (m_awvalid[mw_own] && s_awready) mw_pos = 2;
         end else if (mw_pos == 2) begin
            e_swd = m_wdata[mw_own*8 +: 8]; e_swv = m_wvalid[mw_own];
            e_wready[mw_own] = s_wready;
            if (m_wvalid[mw_own] && s_wready) mw_pos = 3;
         end else begin
            e_bvalid[mw_own] = s_bvalid; e_bresp[mw_own] = s_bresp; e_sbr = m_bready[mw_own];
            if (s_bvalid && m_bready[mw_own]) begin mw_last = mw_own; mw_pos = 0; end
         end
         if (mr_pos == 0) begin
            if (m_arvalid != 2'b00) begin
               mr_own = (m_arvalid == 2'b11) ? 1 - mr_last : (m_arvalid[1] ? 1 : 0);
               mr_pos = 1;
            end
         end else if (mr_pos == 1) begin
            e_sar = m_araddr[mr_own*4 +: 4]; e_sarv = m_arvalid[mr_own];
            e_arready[mr_own] = s_arready;
            if (m_arvalid[mr_own] && s_arready) mr_pos = 2;
         end else begin
            e_rdata[mr_own*8 +: 8] = s_rdata; e_rvalid[mr_own] = s_rvalid;
            e_rresp[mr_own] = s_rresp; e_srr = m_rready[mr_own];
            if (s_rvalid && m_rready[mr_own]) begin mr_last = mr_own; mr_pos = 0; end
         end
      end
      chk("m_awready", m_awready, e_awready);
      chk("m_wready", m_wready, e_wready);
      chk("m_bvalid", m_bvalid, e_bvalid);
      chk("m_bresp", m_bresp, e_bresp);
      chk("m_arready", m_arready, e_arready);
      chk("m_rvalid", m_rvalid, e_rvalid);
      chk("m_rresp", m_rresp, e_rresp);
      chk("m_rdata", m_rdata, e_rdata);
      chk("s_aw", {s_awvalid, s_awaddr}, {e_sawv, e_saw});
      chk("s_w", {s_wvalid, s_wdata}, {e_swv, e_swd});
      chk("s_bready", s_bready, e_sbr);
      chk("s_ar", {s_arvalid, s_araddr}, {e_sarv, e_sar});
      chk("s_rready", s_rready, e_srr);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      stall_max = 0; rdy_rand = 0; bresp_val = 1; rresp_val = 1;
      for (int k = 0; k < 16; k++) mem[k] = 8'h00;
      clear_caps();
      do_reset();

      // reset while a write sits in the data phase: write must not complete
      wa[0][0] = 4'd2; wd[0][0] = 8'h77; wn[0] = 1; w_block = 1;
      drive();
      for (int n = 0; n < 20 && !aw_done[0]; n++) tick();
      tick();
      chk("wdata_phase", 32'(cap_swv), 32'd1);
      do_reset();
      chk("aborted_wr", mem[2], 8'h00);

      // single write from master 0
      clear_caps();
      wa[0][0] = 4'd3; wd[0][0] = 8'hA5; wn[0] = 1;
      drive();
      run_until_done(50, "single_done");
      chk("first_aw_cyc", first_aw, 2);
      chk("s_awaddr", seen_awaddr, 4'd3);
      chk("s_wdata", seen_wdata, 8'hA5);
      chk("bvalid_seen", bv_or, 2'b01);
      chk("bresp_ok", bgot[0][0], 1'b1);
      chk("mem3", mem[3], 8'hA5);

      // contention after reset: strict alternation starting with master 0
      do_reset();
      clear_caps();
      for (int k = 0; k < 4; k++) begin
         wa[0][k] = 4'(k);     wd[0][k] = 8'(8'h20 + k);
         wa[1][k] = 4'(k + 8); wd[1][k] = 8'(8'h80 + k);
      end
      wn[0] = 4; wn[1] = 4;
      drive();
      run_until_done(200, "contend_done");
      chk("order_len", worder.size(), 8);
      for (int k = 0; k < 8 && k < worder.size(); k++) chk("grant_order", worder[k], k % 2);
      chk("mem0", mem[0], 8'h20);
      chk("mem11", mem[11], 8'h83);

      // concurrent write (m0) and read (m1)
      clear_caps();
      mem[5] = 8'h3C;
      wa[0][0] = 4'd1; wd[0][0] = 8'h5A; wn[0] = 1; wi[0] = 0;
      ra[1][0] = 4'd5; rn[1] = 1; ri[1] = 0;
      wn[1] = 0; wi[1] = 0;
      drive();
      run_until_done(50, "concurrent_done");
      chk("m_rdata1", rgot[1][0], 8'h3C);
      chk("rvalid0_never", 32'(rv0_seen), 32'd0);
      chk("mem1", mem[1], 8'h5A);
      chk("rresp_ok", rrgot[1][0], 1'b1);

      // slave stalls and random master ready: 8 bytes each, then readback
      stall_max = 5; rdy_rand = 1;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) begin
            wa[i][k] = 4'(i*8 + k); ra[i][k] = 4'(i*8 + k);
            wd[i][k] = 8'(8'h11 * (k + 1) + i * 8'h40);
         end
         wi[i] = 0; wn[i] = 8; ri[i] = 0; rn[i] = 0;
      end
      drive();
      run_until_done(3000, "stall_wr_done");
      rn[0] = 8; rn[1] = 8;
      drive();
      run_until_done(3000, "stall_rd_done");
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 8; k++) chk("readback", rgot[i][k], wd[i][k]);

      // error responses forwarded unchanged
      stall_max = 0; rdy_rand = 0; bresp_val = 0; rresp_val = 0;
      for (int i = 0; i < 2; i++) begin wi[i] = 0; wn[i] = 0; ri[i] = 0; rn[i] = 0; end
      wa[1][0] = 4'd6; wd[1][0] = 8'h99; wn[1] = 1;
      drive();
      run_until_done(50, "err_wr_done");
      rn[0] = 1; ra[0][0] = 4'd6;
      drive();
      run_until_done(50, "err_rd_done");
      chk("bresp_err", bgot[1][0], 1'b0);
      chk("rresp_err", rrgot[0][0], 1'b0);
      chk("rdata_err", rgot[0][0], 8'h99);

      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
